br_redirect_arbiter: RTL and testbench

//  Collects resolved branch outcomes from NUM_BRU branch units and selects the oldest valid

---
 rtl/br_redirect_arbiter_if.sv | 34 +++
 rtl/br_redirect_arbiter.sv | 109 ++++++++++
 tb/tb_br_redirect_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/br_redirect_arbiter_if.sv
// Bundle between the branch units / ROB / fetch and the redirect arbiter.
// master = arbiter side, slave = surrounding pipeline.
interface br_redirect_arbiter_if #(
  parameter int NUM_BRU = 2,
  parameter int ROB_W   = 4,
  parameter int EPOCH_W = 3
);
  logic [ROB_W-1:0]                    rob_head;
  logic [NUM_BRU-1:0]                  br_valid;
  logic [NUM_BRU-1:0]                  br_mispredict;
  logic [NUM_BRU-1:0][ROB_W-1:0]       br_rob_idx;
  logic [NUM_BRU-1:0][EPOCH_W-1:0]     br_epoch;
  logic [NUM_BRU-1:0][31:0]            br_redirect_pc;
  logic                                commit_valid;
  logic [ROB_W-1:0]                    commit_rob_idx;
  logic                                redirect_valid;
  logic                                redirect_ready;
  logic [31:0]                         redirect_pc;
  logic                                flush_valid;
  logic [ROB_W-1:0]                    flush_rob_idx;
  logic [EPOCH_W-1:0]                  cur_epoch;

  modport master (
    input  rob_head, br_valid, br_mispredict, br_rob_idx, br_epoch, br_redirect_pc,
    input  commit_valid, commit_rob_idx, redirect_ready,
    output redirect_valid, redirect_pc, flush_valid, flush_rob_idx, cur_epoch
  );

  modport slave (
    output rob_head, br_valid, br_mispredict, br_rob_idx, br_epoch, br_redirect_pc,
    output commit_valid, commit_rob_idx, redirect_ready,
    input  redirect_valid, redirect_pc, flush_valid, flush_rob_idx, cur_epoch
  );
endinterface

// File: rtl/br_redirect_arbiter.sv
// Picks the oldest live mispredict across the BRUs, pulses a flush, holds a fetch redirect
// until accepted, and owns the epoch counter. One cycle from accept to outputs; redirect held under !ready.
module br_redirect_arbiter #(
  parameter int NUM_BRU = 2,
  parameter int ROB_W   = 4,
  parameter int EPOCH_W = 3
) (
  input logic                   clk,
  input logic                   rst,
  br_redirect_arbiter_if.master bus
);
  localparam int SEL_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q;
  logic               redirect_valid_q;
  logic [31:0]        redirect_pc_q;
  logic               flush_valid_q;
  logic [ROB_W-1:0]   flush_idx_q;
  logic [EPOCH_W-1:0] cur_epoch_q;
  logic               pend_live_q;
  logic [ROB_W-1:0]   pend_idx_q;
  logic [EPOCH_W-1:0] pend_epoch_q;

  logic [NUM_BRU-1:0]            cand_a_d;
  logic [NUM_BRU-1:0]            cand_b_d;
  logic [NUM_BRU-1:0][ROB_W-1:0] age_d;
  logic [ROB_W-1:0]              pend_age_d;
  logic [ROB_W-1:0]              best_age_d;
  logic [SEL_W-1:0]              win_d;
  logic                          accept_d;
  logic                          win_a_d;

  // Ages are head-relative, so the unsigned subtract absorbs ROB wrap.
  always_comb begin
    pend_age_d = pend_idx_q - bus.rob_head;
    cand_a_d   = '0;
    cand_b_d   = '0;
    age_d      = '0;
    best_age_d = '0;
    win_d      = '0;
    accept_d   = 1'b0;
    for (int i = 0; i < NUM_BRU; i++) begin
      age_d[i]    = bus.br_rob_idx[i] - bus.rob_head;
      cand_a_d[i] = bus.br_valid[i] & bus.br_mispredict[i] & (bus.br_epoch[i] == cur_epoch_q);
      // Late-resolving older branch from the epoch that was already flushed.
      cand_b_d[i] = bus.br_valid[i] & bus.br_mispredict[i] & pend_live_q &
                    (bus.br_epoch[i] == pend_epoch_q) & (age_d[i] < pend_age_d);
      if ((cand_a_d[i] | cand_b_d[i]) && (!accept_d || (age_d[i] < best_age_d))) begin
        accept_d   = 1'b1;
        win_d      = SEL_W'(i);
        best_age_d = age_d[i];
      end
    end
    win_a_d = cand_a_d[win_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_valid_q    <= 1'b0;
      flush_idx_q      <= '0;
      cur_epoch_q      <= '0;
      pend_live_q      <= 1'b0;
      pend_idx_q       <= '0;
      pend_epoch_q     <= '0;
    end else if (accept_d) begin
      // A new accept overrides both handshake completion and pend window close.
      state_q          <= REQ;
      redirect_valid_q <= 1'b1;
      redirect_pc_q    <= bus.br_redirect_pc[win_d];
      flush_valid_q    <= 1'b1;
      flush_idx_q      <= bus.br_rob_idx[win_d];
      cur_epoch_q      <= cur_epoch_q + 1'b1;
      pend_live_q      <= 1'b1;
      pend_idx_q       <= bus.br_rob_idx[win_d];
      if (win_a_d) begin
        pend_epoch_q <= bus.br_epoch[win_d];
      end
    end else begin
      flush_valid_q <= 1'b0;
      case (state_q)
        IDLE: ;
        REQ: begin
          if (bus.redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
      if (pend_live_q && bus.commit_valid && (bus.commit_rob_idx == pend_idx_q)) begin
        pend_live_q <= 1'b0;
      end
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_valid    = flush_valid_q;
  assign bus.flush_rob_idx  = flush_idx_q;
  assign bus.cur_epoch      = cur_epoch_q;
endmodule

// File: tb/tb_br_redirect_arbiter.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_br_redirect_arbiter;
  localparam int NB  = 2;
  localparam int RW  = 4;
  localparam int EW  = 3;
  localparam int RSZ = 1 << RW;
  localparam int ESZ = 1 << EW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_redirect_arbiter_if #(.NUM_BRU(NB), .ROB_W(RW), .EPOCH_W(EW)) bif ();
  br_redirect_arbiter #(.NUM_BRU(NB), .ROB_W(RW), .EPOCH_W(EW)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, expressed directly in terms of the behavioural rules.
  bit          m_req;
  logic [31:0] m_pc;
  bit          m_flush;
  int          m_fidx;
  int          m_epoch;
  bit          m_pend_live;
  int          m_pend_idx;
  int          m_pend_epoch;

  function automatic int age_of(int idx, int head);
    return (idx - head + RSZ) % RSZ;
  endfunction

  // Evaluate the rules on the inputs currently driven, clock once, then commit the model.
  task automatic step();
    int win = -1;
    int best = 0;
    bit win_a = 0;
    int head = int'(bif.rob_head);
    bit rdy = bif.redirect_ready;
    for (int i = 0; i < NB; i++) begin
      int idx = int'(bif.br_rob_idx[i]);
      int ep  = int'(bif.br_epoch[i]);
      bit a, b;
      if (!(bif.br_valid[i] && bif.br_mispredict[i])) continue;
      a = (ep == m_epoch);
      b = m_pend_live && (ep == m_pend_epoch) && (age_of(idx, head) < age_of(m_pend_idx, head));
      if ((a || b) && (win < 0 || age_of(idx, head) < best)) begin
        win = i; best = age_of(idx, head); win_a = a;
      end
    end
    if (rst) begin
      m_req = 0; m_pc = '0; m_flush = 0; m_fidx = 0; m_epoch = 0;
      m_pend_live = 0; m_pend_idx = 0; m_pend_epoch = 0;
    end else if (win >= 0) begin
      m_flush = 1; m_fidx = int'(bif.br_rob_idx[win]); m_pc = bif.br_redirect_pc[win];
      m_req = 1; m_epoch = (m_epoch + 1) % ESZ;
      m_pend_live = 1; m_pend_idx = m_fidx;
      if (win_a) m_pend_epoch = int'(bif.br_epoch[win]);
    end else begin
      m_flush = 0;
      if (m_req && rdy) m_req = 0;
      if (m_pend_live && bif.commit_valid && int'(bif.commit_rob_idx) == m_pend_idx) m_pend_live = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.br_valid = '0; bif.br_mispredict = '0; bif.br_rob_idx = '0; bif.br_epoch = '0;
    bif.br_redirect_pc = '0; bif.commit_valid = 1'b0; bif.commit_rob_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bif.rob_head = '0; bif.redirect_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic set_bru(int i, int idx, int ep, logic [31:0] pc, bit mis);
    bif.br_valid[i] = 1'b1; bif.br_mispredict[i] = mis;
    bif.br_rob_idx[i] = RW'(idx); bif.br_epoch[i] = EW'(ep); bif.br_redirect_pc[i] = pc;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bif.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got %0b exp 0", bif.redirect_valid); end
    n_vec++; if (bif.redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp 0", bif.redirect_pc); end
    n_vec++; if (bif.flush_valid !== 1'b0) begin n_err++; $display("FAIL reset_flush got %0b exp 0", bif.flush_valid); end
    n_vec++; if (bif.flush_rob_idx !== 4'd0) begin n_err++; $display("FAIL reset_fidx got %0d exp 0", bif.flush_rob_idx); end
    n_vec++; if (bif.cur_epoch !== 3'd0) begin n_err++; $display("FAIL reset_epoch got %0d exp 0", bif.cur_epoch); end
  endtask

  task automatic test_single();
    do_reset();
    set_bru(0, 3, 0, 32'h1100, 1); step(); idle_inputs(); bif.redirect_ready = 1'b1;
    n_vec++; if (bif.flush_valid !== 1'b1) begin n_err++; $display("FAIL single_flush got %0b exp 1", bif.flush_valid); end
    n_vec++; if (bif.flush_rob_idx !== 4'd3) begin n_err++; $display("FAIL single_fidx got %0d exp 3", bif.flush_rob_idx); end
    n_vec++; if (bif.redirect_valid !== 1'b1) begin n_err++; $display("FAIL single_rv got %0b exp 1", bif.redirect_valid); end
    n_vec++; if (bif.redirect_pc !== 32'h1100) begin n_err++; $display("FAIL single_pc got %h exp 1100", bif.redirect_pc); end
    n_vec++; if (bif.cur_epoch !== 3'd1) begin n_err++; $display("FAIL single_epoch got %0d exp 1", bif.cur_epoch); end
    step();
    n_vec++; if (bif.flush_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse got %0b exp 0", bif.flush_valid); end
    n_vec++; if (bif.redirect_valid !== 1'b0) begin n_err++; $display("FAIL single_hs got %0b exp 0", bif.redirect_valid); end
  endtask

  task automatic test_oldest();
    do_reset();
    set_bru(0, 5, 0, 32'hA000, 1); set_bru(1, 2, 0, 32'hB000, 1); step();
    n_vec++; if (bif.redirect_pc !== 32'hB000) begin n_err++; $display("FAIL oldest_pc got %h exp b000", bif.redirect_pc); end
    n_vec++; if (bif.flush_rob_idx !== 4'd2) begin n_err++; $display("FAIL oldest_fidx got %0d exp 2", bif.flush_rob_idx); end
    // Correct prediction on the older slot must not win.
    do_reset();
    set_bru(0, 5, 0, 32'hA000, 1); set_bru(1, 2, 0, 32'hB000, 0); step();
    n_vec++; if (bif.redirect_pc !== 32'hA000) begin n_err++; $display("FAIL correct_pred_pc got %h exp a000", bif.redirect_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    bif.rob_head = 4'd14;
    set_bru(0, 1, 0, 32'h0101, 1); set_bru(1, 15, 0, 32'h0F0F, 1); step();
    n_vec++; if (bif.flush_rob_idx !== 4'd15) begin n_err++; $display("FAIL wrap_fidx got %0d exp 15", bif.flush_rob_idx); end
    n_vec++; if (bif.redirect_pc !== 32'h0F0F) begin n_err++; $display("FAIL wrap_pc got %h exp f0f", bif.redirect_pc); end
  endtask

  task automatic test_tie();
    do_reset();
    set_bru(0, 7, 0, 32'h7000, 1); set_bru(1, 7, 0, 32'h7777, 1); step();
    n_vec++; if (bif.redirect_pc !== 32'h7000) begin n_err++; $display("FAIL tie_pc got %h exp 7000", bif.redirect_pc); end
  endtask

  // Override, stale-younger drop, held redirect, then pend window close.
  task automatic test_override_hold();
    logic [31:0] held;
    do_reset();
    set_bru(0, 6, 0, 32'h6000, 1); step(); idle_inputs();
    n_vec++; if (bif.cur_epoch !== 3'd1) begin n_err++; $display("FAIL ovr_epoch1 got %0d exp 1", bif.cur_epoch); end
    set_bru(1, 4, 0, 32'h4000, 1); step(); idle_inputs();
    n_vec++; if (bif.redirect_pc !== 32'h4000) begin n_err++; $display("FAIL ovr_pc got %h exp 4000", bif.redirect_pc); end
    n_vec++; if (bif.redirect_valid !== 1'b1) begin n_err++; $display("FAIL ovr_rv got %0b exp 1", bif.redirect_valid); end
    n_vec++; if (bif.flush_valid !== 1'b1 || bif.flush_rob_idx !== 4'd4) begin n_err++; $display("FAIL ovr_flush got %0b/%0d exp 1/4", bif.flush_valid, bif.flush_rob_idx); end
    n_vec++; if (bif.cur_epoch !== 3'd2) begin n_err++; $display("FAIL ovr_epoch2 got %0d exp 2", bif.cur_epoch); end
    set_bru(0, 9, 0, 32'h9000, 1); step(); idle_inputs();
    n_vec++; if (bif.flush_valid !== 1'b0 || bif.cur_epoch !== 3'd2) begin n_err++; $display("FAIL stale_young got %0b/%0d exp 0/2", bif.flush_valid, bif.cur_epoch); end
    held = bif.redirect_pc;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++; if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h4000) begin n_err++; $display("FAIL hold_%0d got %0b/%h exp 1/4000", c, bif.redirect_valid, bif.redirect_pc); end
    end
    bif.redirect_ready = 1'b1; step(); bif.redirect_ready = 1'b0;
    n_vec++; if (bif.redirect_valid !== 1'b0) begin n_err++; $display("FAIL hs_idle got %0b exp 0", bif.redirect_valid); end
    n_vec++; if (bif.redirect_pc !== held) begin n_err++; $display("FAIL hs_pc got %h exp %h", bif.redirect_pc, held); end
    bif.commit_valid = 1'b1; bif.commit_rob_idx = 4'd4; step(); idle_inputs();
    set_bru(0, 1, 0, 32'h1000, 1); step(); idle_inputs();
    n_vec++; if (bif.flush_valid !== 1'b0 || bif.cur_epoch !== 3'd2) begin n_err++; $display("FAIL closed_win got %0b/%0d exp 0/2", bif.flush_valid, bif.cur_epoch); end
  endtask

  task automatic test_late_older();
    do_reset();
    set_bru(0, 8, 0, 32'h8000, 1); step(); idle_inputs();
    set_bru(1, 2, 0, 32'h2000, 1); step(); idle_inputs();
    n_vec++; if (bif.flush_valid !== 1'b1 || bif.flush_rob_idx !== 4'd2) begin n_err++; $display("FAIL late_old got %0b/%0d exp 1/2", bif.flush_valid, bif.flush_rob_idx); end
    // Same-cycle commit of the pending idx loses to the accept.
    bif.commit_valid = 1'b1; bif.commit_rob_idx = 4'd2; set_bru(0, 1, 0, 32'h1234, 1); step(); idle_inputs();
    n_vec++; if (bif.redirect_pc !== 32'h1234 || bif.cur_epoch !== 3'd3) begin n_err++; $display("FAIL late_prio got %h/%0d exp 1234/3", bif.redirect_pc, bif.cur_epoch); end
    rst = 1'b1; step(); rst = 1'b0;
    n_vec++; if (bif.redirect_valid !== 1'b0 || bif.cur_epoch !== 3'd0) begin n_err++; $display("FAIL mid_rst got %0b/%0d exp 0/0", bif.redirect_valid, bif.cur_epoch); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      bif.rob_head = RW'($urandom_range(0, RSZ - 1));
      for (int i = 0; i < NB; i++) begin
        int sel = $urandom_range(0, 3);
        bif.br_valid[i]       = ($urandom_range(0, 2) == 0);
        bif.br_mispredict[i]  = ($urandom_range(0, 3) != 0);
        bif.br_rob_idx[i]     = RW'($urandom_range(0, RSZ - 1));
        bif.br_epoch[i]       = EW'((sel < 2) ? m_epoch : (sel == 2) ? m_pend_epoch : $urandom_range(0, ESZ - 1));
        bif.br_redirect_pc[i] = $urandom;
      end
      bif.redirect_ready = ($urandom_range(0, 2) == 0);
      bif.commit_valid   = ($urandom_range(0, 3) == 0);
      bif.commit_rob_idx = RW'($urandom_range(0, 1) ? m_pend_idx : $urandom_range(0, RSZ - 1));
      step();
      n_vec++; if (bif.redirect_valid !== m_req) begin n_err++; $display("FAIL rnd_rv c%0d got %0b exp %0b", c, bif.redirect_valid, m_req); end
      n_vec++; if (bif.redirect_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c%0d got %h exp %h", c, bif.redirect_pc, m_pc); end
      n_vec++; if (bif.flush_valid !== m_flush) begin n_err++; $display("FAIL rnd_flush c%0d got %0b exp %0b", c, bif.flush_valid, m_flush); end
      n_vec++; if (int'(bif.flush_rob_idx) !== m_fidx) begin n_err++; $display("FAIL rnd_fidx c%0d got %0d exp %0d", c, bif.flush_rob_idx, m_fidx); end
      n_vec++; if (int'(bif.cur_epoch) !== m_epoch) begin n_err++; $display("FAIL rnd_epoch c%0d got %0d exp %0d", c, bif.cur_epoch, m_epoch); end
    end
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bif.rob_head = '0; bif.redirect_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_oldest();
    test_wrap();
    test_tie();
    test_override_hold();
    test_late_older();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
